mfp_system: RTL and testbench

MFP_SYSTEM -- requirements
Module: mfp_system

---
 rtl/mfp_system_pkg.sv | 40 ++++
 rtl/mfp_ram.sv | 22 ++
 rtl/mfp_system.sv | 248 ++++++++++++++++++++++++
 tb/tb_mfp_system.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_system_pkg.sv
// Shared address map, GPIO register offsets, opcodes and state encoding
// used by the mfp_system sequencer and its bus slaves.
package mfp_system_pkg;

    localparam logic [31:0] MFP_RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] MFP_RESET_BASE = 32'h1FC0_0000;
    localparam logic [31:0] MFP_GPIO_BASE  = 32'h1F80_0000;

    localparam logic [7:0] GPIO_RED    = 8'h00;
    localparam logic [7:0] GPIO_GREEN  = 8'h04;
    localparam logic [7:0] GPIO_SEG    = 8'h08;
    localparam logic [7:0] GPIO_SWITCH = 8'h0C;
    localparam logic [7:0] GPIO_BUTTON = 8'h10;
    localparam logic [7:0] GPIO_LIGHT  = 8'h14;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_COPY  = 2'b01,
        OP_JUMP  = 2'b10,
        OP_HALT  = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        FETCH0_A, FETCH0_D, FETCH1_A, FETCH1_D,
        EXEC_A, EXEC_D, WB_A, WB_D, HALT
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE, SEL_RAM, SEL_BOOT, SEL_GPIO
    } sel_e;

    // Data RAM aliases across its 16 MB window; boot RAM across 4 MB.
    function automatic sel_e decode_sel(input logic [31:0] addr);
        if (addr[31:24] == MFP_RAM_BASE[31:24])   return SEL_RAM;
        if (addr[31:22] == MFP_RESET_BASE[31:22]) return SEL_BOOT;
        if (addr[31:8]  == MFP_GPIO_BASE[31:8])   return SEL_GPIO;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/mfp_ram.sv
// Word-organised single-port RAM with registered read; the word array
// is named ram so simulations can preload it hierarchically.
module mfp_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-3:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] ram [0:(2**(ADDR_WIDTH-2))-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            ram[addr_i] <= wdata_i;
        end
        rdata_o <= ram[addr_i];
    end

endmodule

// File: rtl/mfp_system.sv
// Bus sequencer running a two-word program from boot RAM over data RAM and GPIO.
// Optional light-sensor SPI master enabled by defining MFP_DEMO_LIGHT_SENSOR_EN.
module mfp_system
    import mfp_system_pkg::*;
#(
    parameter int MFP_N_SWITCHES           = 18,
    parameter int MFP_N_BUTTONS            = 5,
    parameter int MFP_N_RED_LEDS           = 18,
    parameter int MFP_N_GREEN_LEDS         = 8,
    parameter int MFP_7_SEGMENT_HEX_WIDTH  = 8,
    parameter int MFP_RESET_RAM_ADDR_WIDTH = 10,
    parameter int MFP_RAM_ADDR_WIDTH       = 12
) (
    input  logic                               SI_ClkIn,
    input  logic                               SI_ColdReset,
    input  logic                               SI_Reset,
    output logic [31:0]                        HADDR,
    output logic [31:0]                        HRDATA,
    output logic [31:0]                        HWDATA,
    output logic                               HWRITE,
    input  logic                               EJ_TRST_N_probe,
    input  logic                               EJ_TDI,
    input  logic                               EJ_TMS,
    input  logic                               EJ_TCK,
    input  logic                               EJ_DINT,
    output logic                               EJ_TDO,
    input  logic [MFP_N_SWITCHES-1:0]          IO_Switches,
    input  logic [MFP_N_BUTTONS-1:0]           IO_Buttons,
    output logic [MFP_N_RED_LEDS-1:0]          IO_RedLEDs,
    output logic [MFP_N_GREEN_LEDS-1:0]        IO_GreenLEDs,
    output logic [MFP_7_SEGMENT_HEX_WIDTH-1:0] IO_7_SegmentHEX,
    input  logic                               UART_RX,
    output logic                               UART_TX,
    output logic                               SPI_CS,
    output logic                               SPI_SCK,
    input  logic                               SPI_SDO
);

    localparam int PC_W = MFP_RESET_RAM_ADDR_WIDTH - 2;

    logic        rst_n;
    state_e      state_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0] haddr_q, hwdata_q, w0_q, w1_q;
    logic        hwrite_q;
    sel_e        sel_d, sel_q;
    logic        wr_commit, ram_we, gpio_we;
    logic [31:0] ram_rdata, boot_rdata, gpio_rd_d, gpio_rd_q;
    logic [15:0] light_w;
    logic [MFP_N_RED_LEDS-1:0]          red_q;
    logic [MFP_N_GREEN_LEDS-1:0]        green_q;
    logic [MFP_7_SEGMENT_HEX_WIDTH-1:0] seg_q;

    function automatic logic [31:0] boot_addr(input logic [PC_W-1:0] pc);
        return MFP_RESET_BASE | 32'({pc, 2'b00});
    endfunction

    assign rst_n   = SI_ColdReset & SI_Reset;
    assign HADDR   = haddr_q;
    assign HWDATA  = hwdata_q;
    assign HWRITE  = hwrite_q;
    assign EJ_TDO  = 1'b0;
    assign UART_TX = 1'b1;

    // Writes commit on the edge that closes the address cycle, unless reset is low.
    assign sel_d     = decode_sel(haddr_q);
    assign wr_commit = hwrite_q && (state_q == EXEC_A || state_q == WB_A);
    assign ram_we    = rst_n && wr_commit && (sel_d == SEL_RAM);
    assign gpio_we   = wr_commit && (sel_d == SEL_GPIO);

    always_ff @(posedge SI_ClkIn) begin
        if (!rst_n) begin
            state_q  <= FETCH0_A;
            pc_q     <= '0;
            haddr_q  <= MFP_RESET_BASE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
        end else begin
            case (state_q)
                FETCH0_A: state_q <= FETCH0_D;
                FETCH0_D: begin
                    w0_q <= HRDATA;
                    if (HRDATA[1:0] == OP_HALT) begin
                        state_q <= HALT;
                    end else begin
                        haddr_q <= boot_addr(pc_q + PC_W'(1));
                        state_q <= FETCH1_A;
                    end
                end
                FETCH1_A: state_q <= FETCH1_D;
                FETCH1_D: begin
                    w1_q <= HRDATA;
                    if (w0_q[1:0] == OP_JUMP) begin
                        pc_q    <= HRDATA[PC_W-1:0];
                        haddr_q <= boot_addr(HRDATA[PC_W-1:0]);
                        state_q <= FETCH0_A;
                    end else begin
                        pc_q     <= pc_q + PC_W'(2);
                        haddr_q  <= {w0_q[31:2], 2'b00};
                        hwrite_q <= (w0_q[1:0] == OP_WRITE);
                        hwdata_q <= (w0_q[1:0] == OP_WRITE) ? HRDATA : 32'h0;
                        state_q  <= EXEC_A;
                    end
                end
                EXEC_A: state_q <= EXEC_D;
                EXEC_D: begin
                    if (w0_q[1:0] == OP_COPY) begin
                        haddr_q  <= w1_q;
                        hwrite_q <= 1'b1;
                        hwdata_q <= HRDATA;
                        state_q  <= WB_A;
                    end else begin
                        haddr_q  <= boot_addr(pc_q);
                        hwrite_q <= 1'b0;
                        hwdata_q <= '0;
                        state_q  <= FETCH0_A;
                    end
                end
                WB_A: state_q <= WB_D;
                WB_D: begin
                    haddr_q  <= boot_addr(pc_q);
                    hwrite_q <= 1'b0;
                    hwdata_q <= '0;
                    state_q  <= FETCH0_A;
                end
                HALT:    state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

    mfp_ram #(.ADDR_WIDTH(MFP_RAM_ADDR_WIDTH)) u_data_ram (
        .clk_i   (SI_ClkIn),
        .we_i    (ram_we),
        .addr_i  (haddr_q[MFP_RAM_ADDR_WIDTH-1:2]),
        .wdata_i (hwdata_q),
        .rdata_o (ram_rdata)
    );

    mfp_ram #(.ADDR_WIDTH(MFP_RESET_RAM_ADDR_WIDTH)) u_boot_ram (
        .clk_i   (SI_ClkIn),
        .we_i    (1'b0),
        .addr_i  (haddr_q[MFP_RESET_RAM_ADDR_WIDTH-1:2]),
        .wdata_i (32'h0),
        .rdata_o (boot_rdata)
    );

    always_ff @(posedge SI_ClkIn) begin
        if (!rst_n) begin
            red_q   <= '0;
            green_q <= '0;
            seg_q   <= '1;
        end else if (gpio_we) begin
            case (haddr_q[7:0])
                GPIO_RED:   red_q   <= hwdata_q[MFP_N_RED_LEDS-1:0];
                GPIO_GREEN: green_q <= hwdata_q[MFP_N_GREEN_LEDS-1:0];
                GPIO_SEG:   seg_q   <= hwdata_q[MFP_7_SEGMENT_HEX_WIDTH-1:0];
                default:    ;
            endcase
        end
    end

    assign IO_RedLEDs      = red_q;
    assign IO_GreenLEDs    = green_q;
    assign IO_7_SegmentHEX = seg_q;

    always_comb begin
        gpio_rd_d = '0;
        case (haddr_q[7:0])
            GPIO_RED:    gpio_rd_d = 32'(red_q);
            GPIO_GREEN:  gpio_rd_d = 32'(green_q);
            GPIO_SEG:    gpio_rd_d = 32'(seg_q);
            GPIO_SWITCH: gpio_rd_d = 32'(IO_Switches);
            GPIO_BUTTON: gpio_rd_d = 32'(IO_Buttons);
            GPIO_LIGHT:  gpio_rd_d = 32'(light_w);
            default:     gpio_rd_d = '0;
        endcase
    end

    // Slave select is registered alongside the read data it steers.
    always_ff @(posedge SI_ClkIn) begin
        sel_q     <= sel_d;
        gpio_rd_q <= gpio_rd_d;
    end

    always_comb begin
        HRDATA = '0;
        case (sel_q)
            SEL_RAM:  HRDATA = ram_rdata;
            SEL_BOOT: HRDATA = boot_rdata;
            SEL_GPIO: HRDATA = gpio_rd_q;
            default:  HRDATA = '0;
        endcase
    end

`ifdef MFP_DEMO_LIGHT_SENSOR_EN
    logic [15:0] tick_q, shift_q, light_q;
    logic [6:0]  bit_cnt_q;
    logic        busy_q, cs_q, sck_q;
    logic        unused_in;

    // One 128-clock frame every 2^16 cycles; SCK is high in clocks 4..7 of each bit.
    always_ff @(posedge SI_ClkIn) begin
        if (!rst_n) begin
            tick_q    <= '0;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            light_q   <= '0;
        end else begin
            tick_q <= tick_q + 16'd1;
            if (!busy_q) begin
                if (tick_q == 16'hFFFF) begin
                    busy_q    <= 1'b1;
                    cs_q      <= 1'b0;
                    bit_cnt_q <= '0;
                end
            end else begin
                bit_cnt_q <= bit_cnt_q + 7'd1;
                sck_q     <= bit_cnt_q[2];
                if (bit_cnt_q[2:0] == 3'd4) begin
                    shift_q <= {shift_q[14:0], SPI_SDO};
                end
                if (bit_cnt_q == 7'd127) begin
                    busy_q  <= 1'b0;
                    cs_q    <= 1'b1;
                    sck_q   <= 1'b0;
                    light_q <= shift_q;
                end
            end
        end
    end

    assign SPI_CS    = cs_q;
    assign SPI_SCK   = sck_q;
    assign light_w   = light_q;
    assign unused_in = ^{EJ_TRST_N_probe, EJ_TDI, EJ_TMS, EJ_TCK, EJ_DINT, UART_RX};
`else
    logic unused_in;

    assign SPI_CS    = 1'b1;
    assign SPI_SCK   = 1'b0;
    assign light_w   = '0;
    assign unused_in = ^{EJ_TRST_N_probe, EJ_TDI, EJ_TMS, EJ_TCK, EJ_DINT, UART_RX, SPI_SDO};
`endif

endmodule

// File: tb/tb_mfp_system.sv
// Self-checking bench for mfp_system: directed programs plus random programs
// compared against an instruction-level model of the boot-RAM sequencer.
module tb_mfp_system;

    logic        clk = 1'b0;
    logic        cold_rst_n, rst_n;
    logic [31:0] haddr, hrdata, hwdata;
    logic        hwrite, tdo, uart_tx, spi_cs, spi_sck;
    logic [17:0] sw;
    logic [4:0]  btn;
    logic [17:0] red;
    logic [7:0]  green, seg;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] boot_m [0:255];
    logic [31:0] dram_m [0:1023];
    logic [31:0] red_m, green_m, seg_m;
    int          pc_m;
    bit          halted_m;

    always #5 clk = ~clk;

    mfp_system dut (
        .SI_ClkIn        (clk),
        .SI_ColdReset    (cold_rst_n),
        .SI_Reset        (rst_n),
        .HADDR           (haddr),
        .HRDATA          (hrdata),
        .HWDATA          (hwdata),
        .HWRITE          (hwrite),
        .EJ_TRST_N_probe (1'b0),
        .EJ_TDI          (1'b0),
        .EJ_TMS          (1'b0),
        .EJ_TCK          (1'b0),
        .EJ_DINT         (1'b0),
        .EJ_TDO          (tdo),
        .IO_Switches     (sw),
        .IO_Buttons      (btn),
        .IO_RedLEDs      (red),
        .IO_GreenLEDs    (green),
        .IO_7_SegmentHEX (seg),
        .UART_RX         (1'b1),
        .UART_TX         (uart_tx),
        .SPI_CS          (spi_cs),
        .SPI_SCK         (spi_sck),
        .SPI_SDO         (1'b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference memory map, evaluated one whole instruction at a time.
    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < 32'h0100_0000) return dram_m[a[11:2]];
        if (a >= 32'h1FC0_0000 && a <= 32'h1FFF_FFFF) return boot_m[a[9:2]];
        case (a)
            32'h1F80_0000: return red_m;
            32'h1F80_0004: return green_m;
            32'h1F80_0008: return seg_m;
            32'h1F80_000C: return {14'h0, sw};
            32'h1F80_0010: return {27'h0, btn};
            default:       return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
        if (a < 32'h0100_0000) dram_m[a[11:2]] = d;
        else if (a == 32'h1F80_0000) red_m = d & 32'h3FFFF;
        else if (a == 32'h1F80_0004) green_m = d & 32'hFF;
        else if (a == 32'h1F80_0008) seg_m = d & 32'hFF;
    endtask

    task automatic model_step(output int cyc);
        logic [31:0] w0, w1, a;
        cyc = 3;
        if (halted_m) return;
        w0 = boot_m[pc_m];
        w1 = boot_m[(pc_m + 1) % 256];
        a  = {w0[31:2], 2'b00};
        case (w0[1:0])
            2'd0: begin m_write(a, w1); pc_m = (pc_m + 2) % 256; cyc = 6; end
            2'd1: begin m_write(w1, m_read(a)); pc_m = (pc_m + 2) % 256; cyc = 8; end
            2'd2: begin pc_m = int'(w1 % 256); cyc = 4; end
            default: halted_m = 1'b1;
        endcase
    endtask

    task automatic step_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Hold a reset, load the program image, release, and restart the model.
    task automatic begin_prog(input bit use_cold);
        @(negedge clk);
        if (use_cold) cold_rst_n = 1'b0; else rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.u_boot_ram.ram[i] = boot_m[i];
        red_m = 0; green_m = 0; seg_m = 32'hFF; pc_m = 0; halted_m = 1'b0;
        cold_rst_n = 1'b1;
        rst_n      = 1'b1;
    endtask

    task automatic run_prog(input string tag, input int nsteps);
        int cyc;
        for (int i = 0; i < nsteps; i++) begin
            model_step(cyc);
            step_cycles(cyc);
            check({tag, ".red"},   {14'h0, red},  red_m);
            check({tag, ".green"}, {24'h0, green}, green_m);
            check({tag, ".seg"},   {24'h0, seg},  seg_m);
            check({tag, ".haddr"}, haddr, 32'h1FC0_0000 + 32'(4 * pc_m));
            check({tag, ".hwrite"}, {31'h0, hwrite}, 32'h0);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom % 12)
            0, 1, 2, 3: return 32'(4 * ($urandom % 16));
            4:  return 32'h0000_1000 + 32'(4 * ($urandom % 16));
            5:  return 32'h1F80_0000;
            6:  return 32'h1F80_0004;
            7:  return 32'h1F80_0008;
            8:  return 32'h1F80_000C;
            9:  return 32'h1F80_0010;
            10: return 32'h1F80_0014;
            default: begin
                case ($urandom % 3)
                    0: return 32'h3000_0000;
                    1: return 32'h1F80_0020;
                    default: return 32'h1FC0_0000 + 32'(4 * ($urandom % 32));
                endcase
            end
        endcase
    endfunction

    task automatic clear_boot();
        for (int i = 0; i < 256; i++) boot_m[i] = 32'h3;
    endtask

    initial begin
        int t;
        cold_rst_n = 1'b0;
        rst_n      = 1'b0;
        sw  = '0;
        btn = '0;
        clear_boot();
        for (int i = 0; i < 1024; i++) begin
            dram_m[i] = $urandom;
            dut.u_data_ram.ram[i] = dram_m[i];
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.haddr",  haddr, 32'h1FC0_0000);
        check("rst.hwrite", {31'h0, hwrite}, 32'h0);
        check("rst.hwdata", hwdata, 32'h0);
        check("rst.red",    {14'h0, red}, 32'h0);
        check("rst.green",  {24'h0, green}, 32'h0);
        check("rst.seg",    {24'h0, seg}, 32'hFF);
        check("rst.spi",    {30'h0, spi_cs, spi_sck}, 32'h2);
        check("rst.tie",    {30'h0, tdo, uart_tx}, 32'h1);

        // First fetches and a WRITE to the red LEDs
        clear_boot();
        boot_m[0] = 32'h1F80_0000; boot_m[1] = 32'h15; boot_m[2] = 32'h3;
        begin_prog(1'b1);
        check("fetch.haddr0", haddr, 32'h1FC0_0000);
        step_cycles(1);
        check("fetch.haddr0d", haddr, 32'h1FC0_0000);
        check("fetch.w0", hrdata, 32'h1F80_0000);
        step_cycles(1);
        check("fetch.haddr1", haddr, 32'h1FC0_0004);
        check("fetch.hwrite", {31'h0, hwrite}, 32'h0);
        step_cycles(1);
        check("fetch.w1", hrdata, 32'h15);
        step_cycles(3);
        check("write.red", {14'h0, red}, 32'h15);
        step_cycles(3);
        check("halt.haddr", haddr, 32'h1FC0_0008);

        // COPY switches to green LEDs in a JUMP 0 loop
        clear_boot();
        boot_m[0] = 32'h1F80_000D; boot_m[1] = 32'h1F80_0004;
        boot_m[2] = 32'h2;         boot_m[3] = 32'h0;
        sw = 18'h000A5;
        begin_prog(1'b0);
        run_prog("loop", 4);
        check("loop.green_a5", {24'h0, green}, 32'hA5);
        sw = 18'h0003C;
        run_prog("loop2", 4);
        check("loop.green_3c", {24'h0, green}, 32'h3C);

        // RAM write then COPY into the segment register
        clear_boot();
        boot_m[0] = 32'h10; boot_m[1] = 32'hDEAD_BEEF;
        boot_m[2] = 32'h11; boot_m[3] = 32'h1F80_0008;
        begin_prog(1'b1);
        run_prog("copy", 3);
        check("copy.seg", {24'h0, seg}, 32'hEF);
        check("copy.ram", dut.u_data_ram.ram[4], 32'hDEAD_BEEF);

        // Boot RAM is read-only; HALT at word 4
        clear_boot();
        boot_m[0] = 32'h1FC0_0000; boot_m[1] = 32'h1234_5678;
        boot_m[2] = 32'h1F80_0000; boot_m[3] = 32'h7;
        begin_prog(1'b0);
        run_prog("ro", 4);
        check("ro.haddr", haddr, 32'h1FC0_0010);
        check("ro.boot0", dut.u_boot_ram.ram[0], 32'h1FC0_0000);

        // Reset during the write-back of a COPY aborts it
        clear_boot();
        boot_m[0] = 32'h1F80_000D; boot_m[1] = 32'h1F80_0000;
        sw = 18'h2AAAA;
        begin_prog(1'b1);
        t = 0;
        while (hwrite !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("abort.wb_seen", {31'h0, hwrite}, 32'h1);
        rst_n = 1'b0;
        step_cycles(1);
        check("abort.red",    {14'h0, red}, 32'h0);
        check("abort.haddr",  haddr, 32'h1FC0_0000);
        check("abort.hwrite", {31'h0, hwrite}, 32'h0);
        check("abort.hwdata", hwdata, 32'h0);
        check("abort.seg",    {24'h0, seg}, 32'hFF);
        check("abort.ram_kept", dut.u_data_ram.ram[4], 32'hDEAD_BEEF);

        // Random WRITE/COPY programs closed by JUMP 0, run twice round the loop
        for (int p = 0; p < 4; p++) begin
            int k;
            k = 6 + int'($urandom % 5);
            clear_boot();
            for (int i = 0; i < k; i++) begin
                if ($urandom % 2 == 0) begin
                    boot_m[2*i]   = pick_addr();
                    boot_m[2*i+1] = $urandom;
                end else begin
                    boot_m[2*i]   = pick_addr() | 32'h1;
                    boot_m[2*i+1] = pick_addr();
                end
            end
            boot_m[2*k]   = 32'h2;
            boot_m[2*k+1] = 32'h0;
            sw  = 18'($urandom);
            btn = 5'($urandom);
            begin_prog(p[0]);
            run_prog($sformatf("rand%0d", p), 2 * (k + 1));
            for (int i = 0; i < 16; i++)
                check($sformatf("rand%0d.ram%0d", p, i), dut.u_data_ram.ram[i], dram_m[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
